// File: rtl/led_shift_ctrl.sv
// Sequencing controller for the 4-bit LED rotator: prescaled advance strobe in
// run / counted-burst / single-step modes, plus a free-running PWM brightness gate.
module led_shift_ctrl #(
    parameter int CNT_W  = 24,
    parameter int DUTY_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [7:0]        cmd_arg,
    input  logic [CNT_W-1:0]  period,
    input  logic              abort,
    input  logic [DUTY_W-1:0] duty,
    output logic              en,
    output logic              pwm,
    output logic              busy,
    output logic              done,
    output logic [7:0]        step_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        BURST = 2'b10,
        STEP  = 2'b11
    } state_e;

    typedef enum logic [1:0] {
        OP_STOP  = 2'b00,
        OP_RUN   = 2'b01,
        OP_BURST = 2'b10,
        OP_STEP  = 2'b11
    } op_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  pc_q, pc_d;
    logic [CNT_W-1:0]  period_q, period_d;
    logic [7:0]        step_q, step_d;
    logic              en_q, en_d;
    logic              done_q, done_d;
    logic              busy_q, busy_d;
    logic [DUTY_W-1:0] pw_q, pw_d;
    logic [DUTY_W-1:0] duty_q, duty_d;
    logic              pwm_q, pwm_d;

    logic              cmd_acc;
    op_e               op;
    logic [CNT_W-1:0]  period_sat;
    logic [7:0]        step_pre;
    logic              counting;

    assign cmd_ready  = (state_q == IDLE) || (state_q == RUN);
    assign cmd_acc    = cmd_valid && cmd_ready;
    assign op         = op_e'(cmd_op);
    assign period_sat = (period == '0) ? CNT_W'(1) : period;

    // Registered outputs show the upcoming cycle's strobe, so every decision below
    // is made on the *_d view of state, prescaler and step count.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
        state_d  = state_q;
        period_d = period_q;
        step_pre = step_q;
        step_d   = step_q;
        en_d     = 1'b0;
        done_d   = 1'b0;
        pc_d     = (pc_q == period_q - CNT_W'(1)) ? '0 : pc_q + CNT_W'(1);

        unique case (state_q)
            IDLE, RUN: begin
                if (cmd_acc) begin
                    unique case (op)
                        OP_STOP: state_d = IDLE;
                        OP_RUN: begin
                            state_d  = RUN;
                            period_d = period_sat;
                            pc_d     = '0;
                        end
                        OP_BURST: begin
                            if (cmd_arg != 8'd0) begin
                                state_d  = BURST;
                                period_d = period_sat;
                                pc_d     = '0;
                                step_pre = cmd_arg;
                            end else begin
                                state_d  = IDLE;
                                done_d   = 1'b1;
                            end
                        end
                        OP_STEP: state_d = STEP;
                    endcase
                end
            end
            BURST: begin
                // done_q marks the final strobe cycle; abort cancels the pending one.
                if (done_q || abort) begin
                    state_d  = IDLE;
                    step_pre = 8'd0;
                end
            end
            STEP: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        counting = (state_d == RUN) || (state_d == BURST);
        step_d   = step_pre;

        if (state_d == STEP) begin
            en_d   = 1'b1;
            done_d = 1'b1;
        end else if (counting && (pc_d == period_d - CNT_W'(1))) begin
            en_d = 1'b1;
            if (state_d == BURST) begin
                step_d = step_pre - 8'd1;
                done_d = (step_pre == 8'd1);
            end
        end

        if (!counting) begin
            pc_d = '0;
        end

        busy_d = (state_d != IDLE);
    end

    // Duty is only picked up at the wrap so a period never mixes two compare values.
    always_comb begin
        pw_d   = pw_q + DUTY_W'(1);
        duty_d = (pw_q == '1) ? duty : duty_q;
        pwm_d  = (pw_d < duty_d);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= IDLE;
            pc_q     <= '0;
            period_q <= CNT_W'(1);
            step_q   <= 8'd0;
            en_q     <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
            pw_q     <= '0;
            duty_q   <= '0;
            pwm_q    <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all flops update together.
            state_q  <= state_d;
            pc_q     <= pc_d;
            period_q <= period_d;
            step_q   <= step_d;
            en_q     <= en_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
            pw_q     <= pw_d;
            duty_q   <= duty_d;
            pwm_q    <= pwm_d;
        end
    end

    assign en       = en_q;
    assign done     = done_q;
    assign busy     = busy_q;
    assign step_cnt = step_q;
    assign pwm      = pwm_q;

endmodule

// File: tb/tb_led_shift_ctrl.sv
// Bench for led_shift_ctrl: table of per-cycle command vectors checked through a
// scoreboard queue, plus hand-written PWM and mid-run reset sequences.
module tb_led_shift_ctrl;
    localparam int CNT_W  = 24;
    localparam int DUTY_W = 8;

    localparam logic [1:0] OP_STOP  = 2'b00;
    localparam logic [1:0] OP_RUN   = 2'b01;
    localparam logic [1:0] OP_BURST = 2'b10;
    localparam logic [1:0] OP_STEP  = 2'b11;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              cmd_valid = 1'b0;
    logic [1:0]        cmd_op = 2'b00;
    logic [7:0]        cmd_arg = 8'd0;
    logic [CNT_W-1:0]  period = '0;
    logic              abort = 1'b0;
    logic [DUTY_W-1:0] duty = '0;
    logic              cmd_ready, en, pwm, busy, done;
    logic [7:0]        step_cnt;

    int n_total = 0;
    int n_pass  = 0;

    led_shift_ctrl #(.CNT_W(CNT_W), .DUTY_W(DUTY_W)) dut (
        .clk      (clk),
        .reset    (reset),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_op   (cmd_op),
        .cmd_arg  (cmd_arg),
        .period   (period),
        .abort    (abort),
        .duty     (duty),
        .en       (en),
        .pwm      (pwm),
        .busy     (busy),
        .done     (done),
        .step_cnt (step_cnt)
    );

    always #5 clk = ~clk;

    // Expected outputs packed as {en, done, busy, cmd_ready, step_cnt[7:0]}.
    typedef struct {
        logic             valid;
        logic [1:0]       op;
        logic [7:0]       arg;
        logic [CNT_W-1:0] per;
        logic             abrt;
        logic [11:0]      exp;
    } vec_t;

    vec_t        vecs[$];
    logic [11:0] sb[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic cyc(input logic v, input logic [1:0] op, input logic [7:0] arg,
                       input int per, input logic ab,
                       input logic e, input logic d, input logic b, input logic r,
                       input logic [7:0] s);
        vec_t x;
        x.valid = v;
        x.op    = op;
        x.arg   = arg;
        x.per   = CNT_W'(per);
        x.abrt  = ab;
        x.exp   = {e, d, b, r, s};
        vecs.push_back(x);
    endtask

    task automatic idle(input logic e, input logic d, input logic b, input logic r,
                        input logic [7:0] s);
        cyc(1'b0, OP_STOP, 8'd0, 0, 1'b0, e, d, b, r, s);
    endtask

    task automatic sb_compare(input int idx);
        logic [11:0] want;
        want = sb.pop_front();
        check($sformatf("vec%0d", idx), {20'd0, en, done, busy, cmd_ready, step_cnt}, {20'd0, want});
    endtask

    task automatic count_high(input int n, output int cnt);
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (pwm === 1'b1) cnt++;
        end
    endtask

    initial begin
        int  cnt;
        logic prev;
        logic found;

        // ---- vector table ----
        // RUN period 4: strobes 4, 8, 12 cycles after accept, then STOP
        cyc(1, OP_RUN, 0, 4, 0, 0, 0, 1, 1, 0);
        for (int j = 1; j <= 11; j++) idle(((j + 1) % 4) == 0, 0, 1, 1, 0);
        cyc(1, OP_STOP, 0, 0, 0, 0, 0, 0, 1, 0);
        idle(0, 0, 0, 1, 0);
        idle(0, 0, 0, 1, 0);
        // RUN reload clears the prescaler
        cyc(1, OP_RUN, 0, 4, 0, 0, 0, 1, 1, 0);
        idle(0, 0, 1, 1, 0);
        cyc(1, OP_RUN, 0, 3, 0, 0, 0, 1, 1, 0);
        idle(0, 0, 1, 1, 0);
        idle(1, 0, 1, 1, 0);
        idle(0, 0, 1, 1, 0);
        idle(0, 0, 1, 1, 0);
        idle(1, 0, 1, 1, 0);
        cyc(1, OP_STOP, 0, 0, 0, 0, 0, 0, 1, 0);
        // BURST 3, period 2; a RUN offered mid-burst is not accepted
        cyc(1, OP_BURST, 3, 2, 0, 0, 0, 1, 0, 3);
        idle(1, 0, 1, 0, 2);
        cyc(1, OP_RUN, 0, 7, 0, 0, 0, 1, 0, 2);
        idle(1, 0, 1, 0, 1);
        idle(0, 0, 1, 0, 1);
        idle(1, 1, 1, 0, 0);
        idle(0, 0, 0, 1, 0);
        idle(0, 0, 0, 1, 0);
        // STEP from IDLE
        cyc(1, OP_STEP, 0, 0, 0, 1, 1, 1, 0, 0);
        idle(0, 0, 0, 1, 0);
        // STEP from RUN ends the run
        cyc(1, OP_RUN, 0, 5, 0, 0, 0, 1, 1, 0);
        idle(0, 0, 1, 1, 0);
        cyc(1, OP_STEP, 0, 0, 0, 1, 1, 1, 0, 0);
        for (int j = 0; j < 6; j++) idle(0, 0, 0, 1, 0);
        // BURST 0: done only
        cyc(1, OP_BURST, 0, 2, 0, 0, 1, 0, 1, 0);
        idle(0, 0, 0, 1, 0);
        // period 0 behaves as 1
        cyc(1, OP_RUN, 0, 0, 0, 1, 0, 1, 1, 0);
        for (int j = 0; j < 3; j++) idle(1, 0, 1, 1, 0);
        cyc(1, OP_STOP, 0, 0, 0, 0, 0, 0, 1, 0);
        idle(0, 0, 0, 1, 0);
        // BURST 1 at period 1: strobe and done on the first cycle
        cyc(1, OP_BURST, 1, 1, 0, 1, 1, 1, 0, 0);
        idle(0, 0, 0, 1, 0);
        // abort where the third strobe of BURST 5 would land
        cyc(1, OP_BURST, 5, 2, 0, 0, 0, 1, 0, 5);
        idle(1, 0, 1, 0, 4);
        idle(0, 0, 1, 0, 4);
        idle(1, 0, 1, 0, 3);
        cyc(0, OP_STOP, 0, 0, 1, 0, 0, 0, 1, 0);
        for (int j = 0; j < 3; j++) idle(0, 0, 0, 1, 0);
        // abort is ignored in RUN
        cyc(1, OP_RUN, 0, 2, 0, 0, 0, 1, 1, 0);
        cyc(0, OP_STOP, 0, 0, 1, 1, 0, 1, 1, 0);
        cyc(0, OP_STOP, 0, 0, 1, 0, 0, 1, 1, 0);
        cyc(0, OP_STOP, 0, 0, 1, 1, 0, 1, 1, 0);
        cyc(1, OP_STOP, 0, 0, 0, 0, 0, 0, 1, 0);

        // ---- reset state ----
        repeat (3) @(negedge clk);
        check("rst_outs", {20'd0, en, done, busy, cmd_ready, step_cnt}, 32'h100);
        check("rst_pwm", {31'd0, pwm}, 32'd0);
        reset = 1'b1;
        @(negedge clk);
        check("ready_after_rst", {31'd0, cmd_ready}, 32'd1);

        // ---- apply table through the scoreboard ----
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            if (sb.size() > 0) sb_compare(i - 1);
            cmd_valid = vecs[i].valid;
            cmd_op    = vecs[i].op;
            cmd_arg   = vecs[i].arg;
            period    = vecs[i].per;
            abort     = vecs[i].abrt;
            sb.push_back(vecs[i].exp);
        end
        @(negedge clk);
        sb_compare(vecs.size() - 1);
        cmd_valid = 1'b0;
        abort     = 1'b0;

        // ---- PWM duty counts per 256-cycle period ----
        count_high(256, cnt);
        check("pwm_duty0", cnt, 0);
        duty = 8'd64;
        repeat (260) @(negedge clk);
        count_high(256, cnt);
        check("pwm_duty64", cnt, 64);
        duty = 8'd255;
        repeat (260) @(negedge clk);
        count_high(256, cnt);
        check("pwm_duty255", cnt, 255);

        // duty change mid-period takes effect only after the wrap
        duty = 8'd64;
        repeat (260) @(negedge clk);
        prev  = pwm;
        found = 1'b0;
        for (int i = 0; i < 600 && !found; i++) begin
            @(negedge clk);
            if (prev === 1'b0 && pwm === 1'b1) found = 1'b1;
            prev = pwm;
        end
        check("pwm_rise_found", {31'd0, found}, 32'd1);
        if (found) begin
            repeat (99) @(negedge clk);
            duty = 8'd200;
            count_high(156, cnt);
            check("pwm_old_duty_rest", cnt, 0);
            count_high(256, cnt);
            check("pwm_new_duty", cnt, 200);
        end

        // ---- reset mid-RUN ----
        duty = 8'd255;
        repeat (300) @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = OP_RUN;
        period    = CNT_W'(6);
        @(negedge clk);
        cmd_valid = 1'b0;
        check("midrun_busy", {31'd0, busy}, 32'd1);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("midrun_rst_outs", {20'd0, en, done, busy, cmd_ready, step_cnt}, 32'h100);
        check("midrun_rst_pwm", {31'd0, pwm}, 32'd0);
        reset = 1'b1;
        @(negedge clk);
        check("post_rst_idle", {29'd0, en, busy, cmd_ready}, 32'd1);
        cmd_valid = 1'b1;
        cmd_op    = OP_RUN;
        period    = CNT_W'(3);
        @(negedge clk);
        cmd_valid = 1'b0;
        check("restart_k1", {30'd0, en, busy}, 32'd1);
        @(negedge clk);
        check("restart_k2", {30'd0, en, busy}, 32'd1);
        @(negedge clk);
        check("restart_k3", {30'd0, en, busy}, 32'd3);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
